// File: rtl/ct_ifu_bht_pred_array_ctrl_pkg.sv
// Shared IFU BHT prediction-array constants and the controller state encoding.
package ct_ifu_bht_pred_array_ctrl_pkg;

  localparam int unsigned BhtDepth = 1024;
  localparam int unsigned BhtIdxW  = 10;
  localparam int unsigned BhtWidth = 64;

  // Every 2-bit counter starts weakly not-taken.
  localparam logic [BhtWidth-1:0] BhtInitVal = {32{2'b01}};

  typedef enum logic {
    StInit = 1'b0,
    StIdle = 1'b1
  } bht_state_e;

endpackage

// File: rtl/ct_ifu_bht_sram_wrap.sv
// Single-port BHT SRAM with its clock-gating cell; behavioural stand-in for the
// ct_spsram_<Depth>x<Width> macro. CEN/GWEN/WEN are active-low, WEN per bit.
module ct_ifu_bht_sram_wrap #(
  parameter int unsigned Depth = 1024,
  parameter int unsigned IdxW  = 10,
  parameter int unsigned Width = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             glb_clk_en_i,
  input  logic             icg_en_i,
  input  logic             scan_en_i,
  input  logic             local_en_i,
  input  logic             cen_i,
  input  logic             gwen_i,
  input  logic [Width-1:0] wen_i,
  input  logic [IdxW-1:0]  addr_i,
  input  logic [Width-1:0] din_i,
  output logic [Width-1:0] q_o
);

  logic             clk_en;
  logic             en_q;
  logic             gclk;
  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] q_q;

  assign clk_en = (glb_clk_en_i & (icg_en_i | local_en_i)) | scan_en_i;

  // Enable is captured while the clock is low so the gated clock never glitches.
  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q <= 1'b0;
    end else begin
      en_q <= clk_en;
    end
  end

  assign gclk = clk_i & en_q;

  // Q holds its last read value across writes and idle cycles.
  always_ff @(posedge gclk) begin
    if (!cen_i) begin
      if (!gwen_i) begin
        mem_q[addr_i] <= (mem_q[addr_i] & wen_i) | (din_i & ~wen_i);
      end else begin
        q_q <= mem_q[addr_i];
      end
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/ct_ifu_bht_pred_array_ctrl.sv
// BHT prediction array controller: init sweep, 1-entry write buffer that yields
// the SRAM port to reads, and read-after-write bypass from that buffer.
module ct_ifu_bht_pred_array_ctrl
  import ct_ifu_bht_pred_array_ctrl_pkg::*;
#(
  parameter int unsigned      Depth   = BhtDepth,
  parameter int unsigned      IdxW    = BhtIdxW,
  parameter int unsigned      Width   = BhtWidth,
  parameter logic [Width-1:0] InitVal = BhtInitVal
) (
  input  logic             forever_cpuclk_i,
  input  logic             cpurst_b_i,
  input  logic             cp0_yy_clk_en_i,
  input  logic             cp0_ifu_icg_en_i,
  input  logic             pad_yy_icg_scan_en_i,
  input  logic             bht_inv_req_i,
  input  logic             bht_rd_vld_i,
  input  logic [IdxW-1:0]  bht_rd_idx_i,
  output logic             bht_rd_ready_o,
  input  logic             bht_wr_vld_i,
  input  logic [IdxW-1:0]  bht_wr_idx_i,
  input  logic [Width-1:0] bht_wr_data_i,
  input  logic [Width-1:0] bht_wr_mask_i,
  output logic             bht_wr_ready_o,
  output logic             bht_rd_data_vld_o,
  output logic [Width-1:0] bht_rd_data_o,
  output logic             bht_init_busy_o
);

  localparam logic [IdxW:0] CntLast = (IdxW + 1)'(Depth - 1);

  bht_state_e       state_q, state_d;
  logic [IdxW:0]    cnt_q, cnt_d;
  logic             wbuf_vld_q, wbuf_vld_d;
  logic [IdxW-1:0]  wbuf_idx_q, wbuf_idx_d;
  logic [Width-1:0] wbuf_data_q, wbuf_data_d;
  logic [Width-1:0] wbuf_mask_q, wbuf_mask_d;
  logic             rd_vld_q, rd_vld_d;
  logic [Width-1:0] byp_data_q, byp_data_d;
  logic [Width-1:0] byp_mask_q, byp_mask_d;

  logic             idle;
  logic             rd_acc;
  logic             wr_acc;
  logic             sram_cen;
  logic             sram_gwen;
  logic [Width-1:0] sram_wen;
  logic [IdxW-1:0]  sram_addr;
  logic [Width-1:0] sram_din;
  logic [Width-1:0] sram_q;
  logic             local_en;

  assign idle           = (state_q == StIdle) & ~bht_inv_req_i;
  assign bht_rd_ready_o = idle;
  assign bht_wr_ready_o = idle & ~(wbuf_vld_q & bht_rd_vld_i);
  assign rd_acc         = bht_rd_vld_i & bht_rd_ready_o;
  assign wr_acc         = bht_wr_vld_i & bht_wr_ready_o;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wbuf_vld_d  = wbuf_vld_q;
    wbuf_idx_d  = wbuf_idx_q;
    wbuf_data_d = wbuf_data_q;
    wbuf_mask_d = wbuf_mask_q;
    rd_vld_d    = rd_acc;
    byp_data_d  = byp_data_q;
    byp_mask_d  = byp_mask_q;
    sram_cen    = 1'b1;
    sram_gwen   = 1'b1;
    sram_wen    = '1;
    sram_addr   = bht_rd_idx_i;
    sram_din    = '0;

    if (bht_inv_req_i) begin
      state_d    = StInit;
      cnt_d      = '0;
      wbuf_vld_d = 1'b0;
    end else if (state_q == StInit) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_addr = cnt_q[IdxW-1:0];
      sram_din  = InitVal;
      cnt_d     = cnt_q + (IdxW + 1)'(1);
      if (cnt_q == CntLast) begin
        state_d = StIdle;
      end
    end else if (rd_acc) begin
      // Read owns the port; a buffered write matching the index is merged next cycle.
      sram_cen   = 1'b0;
      sram_addr  = bht_rd_idx_i;
      byp_data_d = wbuf_data_q;
      byp_mask_d = (wbuf_vld_q && (wbuf_idx_q == bht_rd_idx_i)) ? wbuf_mask_q : '0;
      if (wr_acc) begin
        wbuf_vld_d = 1'b1;
      end
    end else if (wbuf_vld_q) begin
      sram_cen   = 1'b0;
      sram_gwen  = 1'b0;
      sram_wen   = ~wbuf_mask_q;
      sram_addr  = wbuf_idx_q;
      sram_din   = wbuf_data_q;
      wbuf_vld_d = wr_acc;
    end else if (wr_acc) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = ~bht_wr_mask_i;
      sram_addr = bht_wr_idx_i;
      sram_din  = bht_wr_data_i;
    end

    if (!bht_inv_req_i && wr_acc && (rd_acc || wbuf_vld_q)) begin
      wbuf_idx_d  = bht_wr_idx_i;
      wbuf_data_d = bht_wr_data_i;
      wbuf_mask_d = bht_wr_mask_i;
    end
  end

  always_ff @(posedge forever_cpuclk_i or negedge cpurst_b_i) begin
    if (!cpurst_b_i) begin
      state_q     <= StInit;
      cnt_q       <= '0;
      wbuf_vld_q  <= 1'b0;
      wbuf_idx_q  <= '0;
      wbuf_data_q <= '0;
      wbuf_mask_q <= '0;
      rd_vld_q    <= 1'b0;
      byp_data_q  <= '0;
      byp_mask_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wbuf_vld_q  <= wbuf_vld_d;
      wbuf_idx_q  <= wbuf_idx_d;
      wbuf_data_q <= wbuf_data_d;
      wbuf_mask_q <= wbuf_mask_d;
      rd_vld_q    <= rd_vld_d;
      byp_data_q  <= byp_data_d;
      byp_mask_q  <= byp_mask_d;
    end
  end

  assign local_en = bht_init_busy_o | bht_rd_vld_i | wbuf_vld_q | bht_wr_vld_i | bht_inv_req_i;

  ct_ifu_bht_sram_wrap #(
    .Depth (Depth),
    .IdxW  (IdxW),
    .Width (Width)
  ) u_sram (
    .clk_i        (forever_cpuclk_i),
    .rst_ni       (cpurst_b_i),
    .glb_clk_en_i (cp0_yy_clk_en_i),
    .icg_en_i     (cp0_ifu_icg_en_i),
    .scan_en_i    (pad_yy_icg_scan_en_i),
    .local_en_i   (local_en),
    .cen_i        (sram_cen),
    .gwen_i       (sram_gwen),
    .wen_i        (sram_wen),
    .addr_i       (sram_addr),
    .din_i        (sram_din),
    .q_o          (sram_q)
  );

  assign bht_init_busy_o   = (state_q == StInit);
  assign bht_rd_data_vld_o = rd_vld_q;
  assign bht_rd_data_o     = rd_vld_q ? ((sram_q & ~byp_mask_q) | (byp_data_q & byp_mask_q)) : '0;

endmodule
